bit_scan_sequencer: RTL

Downstream consumer of a 4-bit position-encode stage. It accepts a request bit-vector and emits the index of each set bit, one index per output handshake, until the vector is exhausted. Its job is to serialise a multi-hot request word into a stream of positions for a single-issue consumer. The default order is lowest index first, which matches the team's priority-encode convention.

---
 rtl/bit_scan_pkg.sv | 52 +++++
 rtl/bit_scan_sequencer_if.sv | 38 +++
 rtl/bit_scan_pick.sv | 30 +++
 rtl/bit_scan_sequencer.sv | 86 ++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared types and bit-scan helpers for the bit scan sequencer.
// Helpers work on a MAX_W-wide vector; callers zero-extend narrower pends.
package bit_scan_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int unsigned MAX_W = 32;

  function automatic int unsigned lowest_set(
    input logic [MAX_W-1:0] vec
  );
    int unsigned r;
    r = 0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) r = unsigned'(i);
    end
    return r;
  endfunction

  // First set bit at or above ptr, wrapping modulo w (w is a power of 2).
  function automatic int unsigned rot_lowest_set(
    input logic [MAX_W-1:0] vec,
    input int unsigned      ptr,
    input int unsigned      w
  );
    int unsigned r;
    int unsigned idx;
    logic        found;
    r     = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_W; k++) begin
      idx = (ptr + unsigned'(k)) & (w - 1);
      if (unsigned'(k) < w && !found && vec[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic onehot_or_zero(
    input logic [MAX_W-1:0] vec
  );
    logic [MAX_W-1:0] one;
    one = 1;
    return (vec & (vec - one)) == '0;
  endfunction

endpackage

// File: rtl/bit_scan_sequencer_if.sv
// Request-in / position-out handshake bundle for the bit scan sequencer.
// master drives requests and accepts beats; slave is the sequencer.
interface bit_scan_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int POS_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] pos;
  logic             last;
  logic             zero_drop;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  pos,
    input  last,
    input  zero_drop
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output pos,
    output last,
    output zero_drop
  );
endinterface

// File: rtl/bit_scan_pick.sv
// Combinational pick of the next position to serve from the pending bits.
// BIT_SCAN_SEQ_ROTATE_EN adds a round-robin start pointer.
module bit_scan_pick
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] pend,
`ifdef BIT_SCAN_SEQ_ROTATE_EN
  input  logic [POS_W-1:0] ptr,
`endif
  output logic [POS_W-1:0] pos,
  output logic             last
);

  logic [MAX_W-1:0] wide;

  assign wide = MAX_W'(pend);

`ifdef BIT_SCAN_SEQ_ROTATE_EN
  assign pos = POS_W'(rot_lowest_set(wide, 32'(ptr), WIDTH));
`else
  assign pos = POS_W'(lowest_set(wide));
`endif

  // An empty pend must not read as a final beat.
  assign last = (|pend) & onehot_or_zero(wide);

endmodule

// File: rtl/bit_scan_sequencer.sv
// Serialises a multi-hot request vector into one position per beat.
// Define BIT_SCAN_SEQ_ROTATE_EN for round-robin instead of lowest-first order.
module bit_scan_sequencer
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  localparam int POS_W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                reset,
  bit_scan_sequencer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic             zdrop;
  logic [POS_W-1:0] pos;
  logic             last;
  logic             beat;

`ifdef BIT_SCAN_SEQ_ROTATE_EN
  logic [POS_W-1:0] ptr;
`endif

  bit_scan_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .pend  (pend),
`ifdef BIT_SCAN_SEQ_ROTATE_EN
    .ptr   (ptr),
`endif
    .pos   (pos),
    .last  (last)
  );

  assign bus.in_ready  = (state == IDLE) && !reset;
  assign bus.out_valid = (state == SCAN);
  assign bus.pos       = pos;
  assign bus.last      = last;
  assign bus.zero_drop = zdrop;

  assign beat = (state == SCAN) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend  <= '0;
      zdrop <= 1'b0;
`ifdef BIT_SCAN_SEQ_ROTATE_EN
      ptr   <= '0;
`endif
    end else begin
      zdrop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (|bus.in_vec) begin
              pend  <= bus.in_vec;
              state <= SCAN;
            end else begin
              zdrop <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (beat) begin
            pend[pos] <= 1'b0;
`ifdef BIT_SCAN_SEQ_ROTATE_EN
            ptr       <= pos + POS_W'(1);
`endif
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (state != SCAN || |pend)
        else $error("bit_scan_sequencer: empty pend while scanning");
    end
  end

endmodule
